// File: rtl/controlador_de_interrupcao.sv
// rtl/controlador_de_interrupcao.sv - interrupt controller: I/O, external and quantum-timer sources
// Three pending bits served by fixed priority through an IDLE/REQ/SERVICE handshake.
module controlador_de_interrupcao #(
  parameter logic [15:0] QUANTUM = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        userMode,
  input  logic        kernelMode,
  input  logic        ioReq,
  input  logic        extReq,
  input  logic        inta,
  input  logic        clearIntr,
  input  logic [31:0] pcIn,
  output logic        intr,
  output logic [31:0] intrCode,
  output logic [31:0] intrPc,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t      state;
  logic        p_io, p_ext, p_tmr;
  logic        io_prev;
  logic        run;
  logic [15:0] count;

  logic        grant;
  logic        tick;
  logic        set_io, set_ext, set_tmr;
  logic        clr_io, clr_ext, clr_tmr;
  logic [1:0]  win_code;

  always_comb begin
    grant    = (state == REQ) && inta;
    // mode pulses take precedence over the decrement in the same cycle
    tick     = (state == IDLE) && run && !userMode && !kernelMode && (count != 16'd0);
    set_io   = ioReq && !io_prev;
    set_ext  = extReq;
    set_tmr  = tick && (count == 16'd1);
    win_code = p_io ? 2'd1 : p_ext ? 2'd2 : p_tmr ? 2'd3 : 2'd0;
    clr_io   = grant && (win_code == 2'd1);
    clr_ext  = grant && (win_code == 2'd2);
    clr_tmr  = grant && (win_code == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      intr     <= 1'b0;
      busy     <= 1'b0;
      intrCode <= 32'd0;
      intrPc   <= 32'd0;
      p_io     <= 1'b0;
      p_ext    <= 1'b0;
      p_tmr    <= 1'b0;
      io_prev  <= 1'b0;
      run      <= 1'b0;
      count    <= 16'd0;
    end else begin
      io_prev <= ioReq;
      // a new event on the grant edge outlives the clear of its bit
      p_io    <= (p_io  & ~clr_io)  | set_io;
      p_ext   <= (p_ext & ~clr_ext) | set_ext;
      p_tmr   <= (p_tmr & ~clr_tmr) | set_tmr;

      if (kernelMode) begin
        run <= 1'b0;
      end else if (userMode) begin
        count <= QUANTUM;
        run   <= 1'b1;
      end else if (grant) begin
        run <= 1'b0;
      end else if (tick) begin
        count <= count - 16'd1;
        if (count == 16'd1)
          run <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (p_io || p_ext || p_tmr) begin
            state <= REQ;
            intr  <= 1'b1;
          end
        end
        REQ: begin
          if (inta) begin
            state    <= SERVICE;
            intr     <= 1'b0;
            busy     <= 1'b1;
            intrCode <= {30'd0, win_code};
            intrPc   <= pcIn;
          end
        end
        SERVICE: begin
          if (clearIntr) begin
            state    <= IDLE;
            busy     <= 1'b0;
            intrCode <= 32'd0;
          end
        end
        default: begin
          state <= IDLE;
          intr  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
